wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning FIFO address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter AFULL_THRESH, default 12, meaning the wlevel at or above which walmost_full asserts; legal range 1..depth.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; clock port wclk, reset port wrst; no other clocks.
REQ-004 wclk  input  1  write-domain clock; all state updates on posedge.
REQ-005 wrst  input  1  asynchronous active-high reset.
REQ-006 winc  input  1  write request, qualified internally by ~wfull.
REQ-007 rptr_gray  input  ADDR_WIDTH+1  read pointer in Gray code, driven from the read clock domain (asynchronous to wclk).
REQ-008 woverflow_clr  input  1  clears the sticky overflow flag.
REQ-009 waddr  output  ADDR_WIDTH  write address to the FIFO memory.
REQ-010 wclken  output  1  memory write enable, combinational = winc & ~wfull.
REQ-011 wptr  output  ADDR_WIDTH+1  registered Gray write pointer, for synchronisation into the read domain.
REQ-012 wfull  output  1  registered full flag.
REQ-013 walmost_full  output  1  registered almost-full flag.
REQ-014 wlevel  output  ADDR_WIDTH+1  registered occupancy, 0..depth.
REQ-015 woverflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-016 Binary pointer wbin (ADDR_WIDTH+1 bits) SHALL advance by 1 per wclk edge when winc & ~wfull; wraps modulo 2**(ADDR_WIDTH+1).
REQ-017 waddr SHALL equal wbin[ADDR_WIDTH-1:0]; it wraps from depth-1 to 0 while wbin's MSB toggles.
REQ-018 wptr SHALL register gray(wbinnext) = wbinnext ^ (wbinnext >> 1); consecutive values differ in exactly one bit.
REQ-019 rptr_gray SHALL pass through a 2-flop synchroniser (wq2_rptr) before any use; a read-side change reaches wq2_rptr 2 wclk edges later.
REQ-020 wfull SHALL register (gray(wbinnext) == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]}); it asserts on the edge that stores the depth-th unread entry; deassertion is pessimistic (lags reads by 3 edges).
REQ-021 wlevel SHALL register (wbinnext - gray2bin(wq2_rptr)) mod 2**(ADDR_WIDTH+1); wlevel == depth exactly when wfull == 1.
REQ-022 walmost_full SHALL register (that same next level >= AFULL_THRESH), updating on the same edge as wlevel.
REQ-023 Write while full (winc & wfull) SHALL be dropped: wbin, waddr, wptr unchanged, wclken = 0, woverflow set on that edge.
REQ-024 woverflow SHALL clear on an edge with woverflow_clr = 1; if a set and a clear occur on the same edge, set wins.
REQ-025 A write and a read-pointer update on the same edge SHALL both take effect; the level result is consistent with both.

Reset
REQ-026 While wrst = 1, wbin, wptr, both synchroniser stages, wfull, walmost_full, wlevel and woverflow SHALL be 0 immediately, without waiting for a clock edge; waddr = 0; wclken = winc.
REQ-027 Reset asserted mid-operation SHALL discard all pointer and flag state with no partial update; the first write after release uses waddr = 0.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the ADDR_WIDTH default, the gray2bin/bin2gray functions and the pointer typedef ptr_t (ADDR_WIDTH+1 bits).
REQ-029 The 2-flop synchroniser SHALL be a separate sub-module sync_r2w (parameterised width, async active-high reset); it is reused for the mirrored read-side block.

Verification (ADDR_WIDTH=4, AFULL_THRESH=12)
REQ-030 Fill: rptr_gray = 0, 16 writes -> after the 16th edge: wfull = 1, wlevel = 16, waddr = 0, wptr = 5'b11000, walmost_full = 1 from the 12th edge.
REQ-031 Overflow: while full, winc = 1 for 1 cycle -> wclken = 0, waddr and wptr unchanged, woverflow = 1; woverflow_clr = 1 -> 0 next edge; set+clr on the same edge -> stays 1.
REQ-032 Drain visibility: full, rptr_gray steps to 5'b00110 (bin 4) -> wfull = 0 and wlevel = 12 on the 3rd wclk edge, not earlier.
REQ-033 Wrap: 40 writes with the read side keeping the level <= 8 -> waddr goes 15 -> 0, wptr MSB toggles, every wptr transition is a single-bit change, wfull never asserts.
REQ-034 Reset mid-fill: wrst pulsed after 7 writes, asynchronous to wclk -> all outputs 0 before the next edge; the next write uses waddr = 0, wlevel = 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer width, pointer type and Gray-code helpers
package fifo_pkg;
    localparam int DEF_ADDR_WIDTH = 4;
    typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
    // Helpers work on a 32-bit word so any pointer width can use them through a size cast
    typedef logic [31:0] word_t;
    function automatic word_t bin2gray(word_t b);
        return b ^ (b >> 1);
    endfunction
    function automatic word_t gray2bin(word_t g);
        word_t b;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/sync_r2w.sv
// sync_r2w: two-flop synchroniser for a pointer crossing into this clock domain
module sync_r2w
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q1;
    always_ff @(posedge clk or posedge rst)
        if (rst) {q, q1} <= '0;
        else {q, q1} <= {q1, d};
endmodule

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: async FIFO write-side pointer, full/almost-full, level and overflow control
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic                  woverflow_clr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wclken,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);
    localparam int PW = ADDR_WIDTH + 1;
    logic [ADDR_WIDTH:0] wbin, wbinnext, wgraynext, wq2_rptr, wlevel_next;
    logic wfull_next, walmost_full_next;
    sync_r2w #(.WIDTH(PW)) u_sync (.clk(wclk), .rst(wrst), .d(rptr_gray), .q(wq2_rptr));
    assign waddr = wbin[ADDR_WIDTH-1:0];
    // Full when the next write pointer equals the synced read pointer with its top two Gray bits inverted
    always_comb begin
        wclken            = winc & ~wfull;
        wbinnext          = wbin + PW'(wclken);
        wgraynext         = PW'(bin2gray(32'(wbinnext)));
        wlevel_next       = wbinnext - PW'(gray2bin(32'(wq2_rptr)));
        wfull_next        = wgraynext == {~wq2_rptr[ADDR_WIDTH -: 2], wq2_rptr[ADDR_WIDTH-2:0]};
        walmost_full_next = 32'(wlevel_next) >= 32'(AFULL_THRESH);
    end
    always_ff @(posedge wclk or posedge wrst)
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
            woverflow    <= (winc & wfull) | (woverflow & ~woverflow_clr);
        end
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: scoreboard bench for the FIFO write-side controller
module tb_wptr_full_ctrl;
    logic       wclk = 1'b0, wrst = 1'b1, winc = 1'b0, woverflow_clr = 1'b0;
    logic [4:0] rptr_gray = '0;
    logic [3:0] waddr;
    logic       wclken, wfull, walmost_full, woverflow;
    logic [4:0] wptr, wlevel;
    int checks = 0, failures = 0;

    wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr_gray(rptr_gray),
        .woverflow_clr(woverflow_clr), .waddr(waddr), .wclken(wclken), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       waf;
        logic [4:0] wlevel;
        logic       wovf;
    } exp_t;
    exp_t exp_q[$];

    logic [4:0] m_wbin, m_q1, m_q2;
    logic       m_full, m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic model_reset;
        m_wbin = '0; m_q1 = '0; m_q2 = '0; m_full = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_waddr"}, waddr, 0);
        chk({tag, "_wptr"}, wptr, 0);
        chk({tag, "_wfull"}, wfull, 0);
        chk({tag, "_waf"}, walmost_full, 0);
        chk({tag, "_wlevel"}, wlevel, 0);
        chk({tag, "_wovf"}, woverflow, 0);
        chk({tag, "_wclken"}, wclken, winc);
    endtask

    // one write-clock cycle: drive, predict into the queue, clock, pop and compare
    task automatic step(input logic wi, input logic [4:0] rp, input logic clr);
        exp_t e;
        logic en;
        logic [4:0] nb, lvl;
        winc = wi; rptr_gray = rp; woverflow_clr = clr;
        #1;
        en = wi & ~m_full;
        chk("wclken", wclken, en);
        nb  = m_wbin + 5'(en);
        lvl = nb - g2b(m_q2);
        e.waddr  = nb[3:0];
        e.wptr   = b2g(nb);
        e.wfull  = (lvl == 5'd16);
        e.waf    = (lvl >= 5'd12);
        e.wlevel = lvl;
        e.wovf   = (wi & m_full) | (m_ovf & ~clr);
        exp_q.push_back(e);
        m_wbin = nb; m_q2 = m_q1; m_q1 = rp; m_full = e.wfull; m_ovf = e.wovf;
        @(posedge wclk);
        #1;
        e = exp_q.pop_front();
        chk("waddr", waddr, e.waddr);
        chk("wptr", wptr, e.wptr);
        chk("wfull", wfull, e.wfull);
        chk("walmost_full", walmost_full, e.waf);
        chk("wlevel", wlevel, e.wlevel);
        chk("woverflow", woverflow, e.wovf);
    endtask

    initial begin
        logic [3:0] a;
        logic [4:0] p, rd, wr;
        int wraps, msb_flips;
        repeat (2) @(posedge wclk);
        #1;
        chk_reset_outputs("rst");
        winc = 1'b1;
        #1;
        chk("rst_wclken_follows", wclken, 1);
        winc = 1'b0;
        wrst = 1'b0;
        model_reset();

        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 5'd0, 1'b0);
            chk("fill_af", walmost_full, k >= 12);
            chk("fill_full", wfull, k == 16);
        end
        chk("fill_wlevel", wlevel, 16);
        chk("fill_waddr", waddr, 0);
        chk("fill_wptr", wptr, 5'b11000);

        a = waddr; p = wptr;
        step(1'b1, 5'd0, 1'b0);
        chk("ovf_waddr_hold", waddr, a);
        chk("ovf_wptr_hold", wptr, p);
        chk("ovf_set", woverflow, 1);
        step(1'b0, 5'd0, 1'b1);
        chk("ovf_clr", woverflow, 0);
        step(1'b1, 5'd0, 1'b1);
        chk("ovf_set_beats_clr", woverflow, 1);
        step(1'b0, 5'd0, 1'b1);

        step(1'b0, 5'b00110, 1'b0);
        chk("drain_e1_full", wfull, 1);
        step(1'b0, 5'b00110, 1'b0);
        chk("drain_e2_full", wfull, 1);
        step(1'b0, 5'b00110, 1'b0);
        chk("drain_e3_full", wfull, 0);
        chk("drain_e3_lvl", wlevel, 12);

        rd = 5'd4;
        for (int i = 0; i < 12; i++) begin
            rd++;
            step(1'b0, b2g(rd), 1'b0);
        end
        repeat (3) step(1'b0, b2g(rd), 1'b0);
        chk("empty_lvl", wlevel, 0);

        wr = 5'd16; wraps = 0; msb_flips = 0;
        for (int n = 0; n < 40; n++) begin
            a = waddr; p = wptr;
            if (5'(wr - rd) > 5'd4) rd++;
            step(1'b1, b2g(rd), 1'b0);
            wr++;
            chk("wrap_1bit", $countones(wptr ^ p), 1);
            chk("wrap_nofull", wfull, 0);
            chk("wrap_lvl_le8", wlevel <= 5'd8, 1);
            if (a == 4'd15 && waddr == 4'd0) wraps++;
            if (p[4] != wptr[4]) msb_flips++;
        end
        chk("wrap_count", wraps, 2);
        chk("wrap_msb_flips", msb_flips, 2);

        wrst = 1'b1; winc = 1'b0; rptr_gray = '0; woverflow_clr = 1'b0;
        #1;
        wrst = 1'b0;
        model_reset();
        repeat (7) step(1'b1, 5'd0, 1'b0);
        chk("mid_waddr7", waddr, 7);
        #2;
        wrst = 1'b1;
        winc = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        wrst = 1'b0;
        #1;
        model_reset();
        chk("post_rst_waddr", waddr, 0);
        step(1'b1, 5'd0, 1'b0);
        chk("post_rst_lvl", wlevel, 1);
        chk("post_rst_waddr1", waddr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
